instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Write-side front end for the instruction memory. It accepts a program as a byte stream from the debug/UART path and assembles each group of 4 bytes into a 32-bit instruction, MSB first. It writes each instruction into the instruction memory write port at byte addresses 0, 4, 8, …, matching PC stepping. Loading ends on the HALT word (all ones) or on memory exhaustion.

Parameters:
NBITS, 32, instruction/address width
NBYTE, 8, width of incoming stream symbol
CELDAS, 60, number of instruction memory cells; valid write addresses are 0..CELDAS-1
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse; arms a new load
i_byte  in  NBYTE  stream data
i_byte_valid  in  1  stream data valid
o_byte_ready  out  1  loader can accept a byte
o_wr_en  out  1  instruction memory write strobe, 1 cycle per word
o_wr_addr  out  NBITS  write address (byte address, multiple of 4)
o_wr_data  out  NBITS  assembled instruction
o_busy  out  1  load in progress (RECV or WRITE)
o_done  out  1  HALT word written; sticky until next i_start
o_error  out  1  memory filled with no HALT; sticky until next i_start
o_word_count  out  8  words written in current load, HALT included

Behaviour:
- Reset (async, i_reset_n=0): state IDLE. All outputs 0. Internal address, byte counter and shift register are 0. Takes effect immediately, including mid-word; any partial word is discarded.
- Byte transfer occurs on a rising edge with i_byte_valid=1 and o_byte_ready=1. i_byte_valid with ready=0 is ignored; no transfer occurs.
- State IDLE: o_byte_ready=0. On i_start go to RECV and clear address, byte counter, o_word_count, o_done and o_error.
- State RECV: o_byte_ready=1 and o_busy=1.
  - Each transfer shifts the byte in: data <= {data[23:0], i_byte}, so the first byte lands in [31:24].
  - Byte counter runs 0..3. The transfer with counter=3 moves the FSM to WRITE.
  - Gaps in valid are allowed indefinitely.
- State WRITE, exactly 1 cycle:
  - o_wr_en=1 with o_wr_addr = current address and o_wr_data = assembled word. o_byte_ready=0.
  - o_word_count increments.
  - The write strobe appears on the cycle after the 4th byte is accepted.
- Next state after WRITE:
  - If the word == HALT_WORD, go to DONE. The HALT check has priority over the overflow check.
  - Else if address+4 > CELDAS-1, go to ERROR.
  - Else address += 4, byte counter = 0, go to RECV.
- With CELDAS=60 the last writable address is 56, so a program holds at most 15 words including HALT.
- State DONE: o_done=1, o_busy=0, ready=0. Stays until i_start, which re-arms exactly as from IDLE.
- State ERROR: o_error=1, o_busy=0, ready=0. Leaves on i_start, same as DONE.
- i_start during RECV or WRITE is ignored. A load cannot be aborted except by reset.
- o_wr_addr and o_wr_data are registered. They hold their last values when o_wr_en=0.
- o_word_count saturates at 255 (never reached with the default CELDAS).

Test Plan:
- Reset release, pulse i_start, send 00 00 08 20, AC 00 01 00, FF FF FF FF with valid always 1 -> writes (0,32'h00000820), (4,32'hAC000100), (8,32'hFFFFFFFF); o_done=1 after the third write; o_word_count=3; o_byte_ready=0 afterwards.
- Same stream with i_byte_valid toggling 1/0 every cycle -> identical write sequence; each o_wr_en is 1 cycle and follows the 4th accepted byte by 1 cycle.
- Send 15 non-HALT words (16'h0000 pattern) -> last write at address 56; o_error=1, o_done=0, o_word_count=15; no write at address 60.
- Send 14 non-HALT words then HALT -> HALT written at address 56; o_done=1, o_error=0.
- Assert i_reset_n=0 after 2 bytes of word 1, release, i_start, send a full HALT word -> single write (0, FFFFFFFF); the pre-reset bytes do not appear in o_wr_data.
- Pulse i_start mid-load (after 6 bytes) -> ignored; address and count continue. After DONE, pulse i_start -> o_done cleared, o_word_count=0, next word written at address 0.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: groups the loader's control, byte-stream and
// instruction-memory write-port signals.
//   slave  : loader side (consumes start/byte stream, drives write port/status)
//   master : host/bench side (drives start/byte stream, observes the rest)
// Signal names follow the loader's external naming (i_* into the loader,
// o_* out of it).
interface instr_mem_loader_if #(
  parameter int NBITS = 32,
  parameter int NBYTE = 8
);
  logic             i_start;
  logic [NBYTE-1:0] i_byte;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic             o_wr_en;
  logic [NBITS-1:0] o_wr_addr;
  logic [NBITS-1:0] o_wr_data;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [7:0]       o_word_count;

  modport slave (
    input  i_start, i_byte, i_byte_valid,
    output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_busy, o_done, o_error, o_word_count
  );

  modport master (
    output i_start, i_byte, i_byte_valid,
    input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
           o_busy, o_done, o_error, o_word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: write-side front end of the instruction memory.
// Collects NBITS/NBYTE stream bytes (MSB first) into one instruction and
// writes it at byte addresses 0, 4, 8, ... Loading stops on HALT_WORD
// (o_done) or when the next address would pass CELDAS-1 (o_error).
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        instr_mem_loader_if.slave: i_start, byte stream with
//              valid/ready, write port (o_wr_en/addr/data), status
//              (o_busy, o_done, o_error, o_word_count)
module instr_mem_loader #(
  parameter int                NBITS     = 32,
  parameter int                NBYTE     = 8,
  parameter int                CELDAS    = 60,
  parameter logic [NBITS-1:0]  HALT_WORD = {NBITS{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  instr_mem_loader_if.slave bus
);

  localparam int NB = NBITS / NBYTE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NB - 1);
  localparam logic [NBITS:0] LAST_ADDR = (NBITS+1)'(CELDAS - 1);
  localparam logic [NBITS:0] ADDR_STEP = (NBITS+1)'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] wr_addr_q, wr_addr_d;
  logic [NBITS-1:0] wr_data_q, wr_data_d;
  logic [7:0]       word_cnt_q, word_cnt_d;

  logic             xfer;
  logic [NBITS-1:0] shifted;
  logic [NBITS:0]   next_addr;

  assign xfer      = bus.i_byte_valid && (state_q == S_RECV);
  assign shifted   = {data_q[NBITS-NBYTE-1:0], bus.i_byte};
  // One extra bit so the overflow compare cannot be fooled by wrap-around.
  assign next_addr = {1'b0, addr_q} + ADDR_STEP;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Leaving DONE/ERROR is what clears the sticky status bits.
        if (bus.i_start) begin
          state_d    = S_RECV;
          addr_d     = '0;
          cnt_d      = '0;
          word_cnt_d = '0;
        end
      end
      S_RECV: begin
        if (xfer) begin
          data_d = shifted;
          if (cnt_q == LAST_BYTE) begin
            // Capture the write port here so it is registered and valid
            // during the WRITE cycle, then simply holds afterwards.
            state_d   = S_WRITE;
            wr_addr_d = addr_q;
            wr_data_d = shifted;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
        cnt_d = '0;
        // HALT wins over overflow: a HALT in the last cell is a clean finish.
        if (data_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (next_addr > LAST_ADDR) begin
          state_d = S_ERROR;
        end else begin
          addr_d  = next_addr[NBITS-1:0];
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.o_byte_ready = (state_q == S_RECV);
  assign bus.o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.o_wr_en      = (state_q == S_WRITE);
  assign bus.o_done       = (state_q == S_DONE);
  assign bus.o_error      = (state_q == S_ERROR);
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_word_count = word_cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scoreboard bench for instr_mem_loader.
// Stimulus pushes each expected (addr, data) write into a queue; a monitor
// pops and compares on every o_wr_en and also checks that each strobe lands
// exactly one cycle after the 4th accepted byte of a word.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.NBITS(32), .NBYTE(8)) bus ();

  instr_mem_loader #(
    .NBITS(32), .NBYTE(8), .CELDAS(60), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  // Independent byte-position tracker for strobe timing.
  logic [1:0] tb_bcnt;
  logic       acc4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_bcnt <= 2'd0;
      acc4    <= 1'b0;
    end else begin
      acc4 <= bus.i_byte_valid && bus.o_byte_ready && (tb_bcnt == 2'd3);
      if (bus.i_byte_valid && bus.o_byte_ready) tb_bcnt <= tb_bcnt + 2'd1;
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.o_wr_en === 1'b1 || acc4) begin
      vectors++;
      if (bus.o_wr_en !== acc4) begin
        miscompares++;
        $display("FAIL wr_en_timing actual=%b expected=%b t=%0t", bus.o_wr_en, acc4, $time);
      end
    end
    if (bus.o_wr_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.o_wr_addr, bus.o_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_wr_addr, bus.o_wr_data} !== e) begin
          miscompares++;
          $display("FAIL write actual=(%h,%h) expected=(%h,%h)",
                   bus.o_wr_addr, bus.o_wr_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; valid is left high (caller drops it).
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    while (bus.o_byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    @(negedge clk);
    if (gap) begin
      bus.i_byte_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit gap);
    exp_q.push_back({addr, w});
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic pulse_start();
    bus.i_byte_valid = 1'b0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    bus.i_byte_valid = 1'b0;
    while (!(bus.o_done === 1'b1 || bus.o_error === 1'b1) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL end_timeout actual=busy expected=done_or_error");
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_byte = 8'h00;
    bus.i_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    check("rst_busy",  32'(bus.o_busy), 32'd0);
    check("rst_done",  32'(bus.o_done), 32'd0);
    check("rst_error", 32'(bus.o_error), 32'd0);
    check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("rst_addr",  bus.o_wr_addr, 32'd0);
    check("rst_data",  bus.o_wr_data, 32'd0);
    check("rst_count", 32'(bus.o_word_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic program, valid always high, then again with gaps.
    for (int g = 0; g < 2; g++) begin
      pulse_start();
      send_word(32'd0, 32'h0000_0820, g[0]);
      send_word(32'd4, 32'hAC00_0100, g[0]);
      send_word(32'd8, 32'hFFFF_FFFF, g[0]);
      wait_end();
      check("prog_done",  32'(bus.o_done), 32'd1);
      check("prog_error", 32'(bus.o_error), 32'd0);
      check("prog_count", 32'(bus.o_word_count), 32'd3);
      check("prog_ready", 32'(bus.o_byte_ready), 32'd0);
      check("prog_busy",  32'(bus.o_busy), 32'd0);
      check("prog_drain", 32'(exp_q.size()), 32'd0);
    end

    // Fill memory without HALT.
    pulse_start();
    check("restart_done_clr", 32'(bus.o_done), 32'd0);
    for (int i = 0; i < 15; i++) send_word(32'(i * 4), {16'h0000, 16'(i)}, 1'b0);
    wait_end();
    repeat (4) @(negedge clk);
    check("ovf_error", 32'(bus.o_error), 32'd1);
    check("ovf_done",  32'(bus.o_done), 32'd0);
    check("ovf_count", 32'(bus.o_word_count), 32'd15);
    check("ovf_addr",  bus.o_wr_addr, 32'd56);

    // HALT in the last cell.
    pulse_start();
    check("restart_err_clr", 32'(bus.o_error), 32'd0);
    for (int i = 0; i < 14; i++) send_word(32'(i * 4), {16'h0000, 16'(i)}, 1'b0);
    send_word(32'd56, 32'hFFFF_FFFF, 1'b0);
    wait_end();
    check("last_done",  32'(bus.o_done), 32'd1);
    check("last_error", 32'(bus.o_error), 32'd0);
    check("last_count", 32'(bus.o_word_count), 32'd15);

    // Reset mid-word discards partial data.
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    bus.i_byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("midrst_busy",  32'(bus.o_busy), 32'd0);
    check("midrst_data",  bus.o_wr_data, 32'd0);
    check("midrst_count", 32'(bus.o_word_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_word(32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_end();
    check("midrst_done",   32'(bus.o_done), 32'd1);
    check("midrst_count1", 32'(bus.o_word_count), 32'd1);
    check("midrst_wdata",  bus.o_wr_data, 32'hFFFF_FFFF);

    // i_start mid-load is ignored.
    pulse_start();
    send_word(32'd0, 32'h1234_5678, 1'b0);
    exp_q.push_back({32'd4, 32'h9ABC_DEF0});
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    pulse_start();
    check("ign_busy",  32'(bus.o_busy), 32'd1);
    check("ign_count", 32'(bus.o_word_count), 32'd1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_word(32'd8, 32'hFFFF_FFFF, 1'b0);
    wait_end();
    check("ign_done",   32'(bus.o_done), 32'd1);
    check("ign_count3", 32'(bus.o_word_count), 32'd3);

    // Re-arm after DONE restarts at address 0.
    pulse_start();
    check("rearm_done",  32'(bus.o_done), 32'd0);
    check("rearm_count", 32'(bus.o_word_count), 32'd0);
    check("rearm_busy",  32'(bus.o_busy), 32'd1);
    send_word(32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_end();
    check("rearm_count1", 32'(bus.o_word_count), 32'd1);
    repeat (3) @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
